// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART definitions: transmitter FSM state encoding and
//               the board default bit period (27 MHz clock, 115200 baud).
//               Also used by the existing receiver.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Clock cycles per bit: 27_000_000 / 115200 = 234 (integer division).
    localparam int DEFAULT_BAUDRATE_CNT = 27_000_000 / 115200;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_serializer
// Description : 8N1 serializer, LSB first. A byte is accepted on the edge where
//               load is high in IDLE; the start bit appears on the following
//               cycle. Each bit lasts BAUDRATE_CNT cycles.
// Ports       : clk, rst_n (async, active-low)
//               load  - accept data this cycle (honoured only in IDLE)
//               data  - byte to transmit
//               busy  - frame in flight (START..STOP)
//               done  - one-cycle pulse on the last cycle of the stop bit
//               tx    - registered serial line, idle high
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int BAUDRATE_CNT = DEFAULT_BAUDRATE_CNT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] data,
    output logic       busy,
    output logic       done,
    output logic       tx
);

    localparam int              CW        = $clog2(BAUDRATE_CNT);
    localparam logic [CW-1:0]   BAUD_LAST = CW'(BAUDRATE_CNT - 1);

    tx_state_t     state, state_n;
    logic [CW-1:0] baud_cnt, baud_cnt_n;
    logic [2:0]    bit_idx, bit_idx_n;
    logic [7:0]    shift, shift_n;
    logic          tx_n;
    logic          bit_end;

    assign bit_end = (baud_cnt == BAUD_LAST);
    assign busy    = (state != ST_IDLE);
    assign done    = (state == ST_STOP) && bit_end;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            tx       <= 1'b1;
        end else begin
            state    <= state_n;
            baud_cnt <= baud_cnt_n;
            bit_idx  <= bit_idx_n;
            shift    <= shift_n;
            tx       <= tx_n;
        end
    end

    // tx_n is the line level for the *next* cycle, so the registered line
    // follows the state register without an extra cycle of latency.
    always_comb begin
        state_n    = state;
        baud_cnt_n = baud_cnt;
        bit_idx_n  = bit_idx;
        shift_n    = shift;
        tx_n       = 1'b1;

        case (state)
            ST_IDLE: begin
                baud_cnt_n = '0;
                bit_idx_n  = '0;
                if (load) begin
                    state_n = ST_START;
                    shift_n = data;
                    tx_n    = 1'b0;
                end
            end

            ST_START: begin
                tx_n = 1'b0;
                if (bit_end) begin
                    state_n    = ST_DATA;
                    baud_cnt_n = '0;
                    bit_idx_n  = '0;
                    tx_n       = shift[0];
                end else begin
                    baud_cnt_n = baud_cnt + CW'(1);
                end
            end

            ST_DATA: begin
                tx_n = shift[0];
                if (bit_end) begin
                    baud_cnt_n = '0;
                    shift_n    = {1'b0, shift[7:1]};
                    bit_idx_n  = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        state_n = ST_STOP;
                        tx_n    = 1'b1;
                    end else begin
                        tx_n    = shift[1];
                    end
                end else begin
                    baud_cnt_n = baud_cnt + CW'(1);
                end
            end

            ST_STOP: begin
                tx_n = 1'b1;
                if (bit_end) begin
                    state_n    = ST_IDLE;
                    baud_cnt_n = '0;
                end else begin
                    baud_cnt_n = baud_cnt + CW'(1);
                end
            end

            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

endmodule : uart_tx_serializer
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Round-robin arbiter sharing one 8N1 UART transmitter between
//               two byte requesters with valid/ready handshakes.
// Ports       : clk, rst_n (async, active-low)
//               req_valid[1:0] - requester i has a byte pending
//               req_data0/1    - bytes from requesters 0 and 1
//               req_ready[1:0] - one-hot accept strobe (IDLE only)
//               uart_tx        - serial line, idle high, registered
//               busy           - frame in flight
//               grant_id       - requester owning the current/last frame
//               frame_done     - pulse on the last stop-bit cycle
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int BAUDRATE_CNT = DEFAULT_BAUDRATE_CNT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_valid,
    input  logic [7:0] req_data0,
    input  logic [7:0] req_data1,
    output logic [1:0] req_ready,
    output logic       uart_tx,
    output logic       busy,
    output logic       grant_id,
    output logic       frame_done
);

    logic       ptr;
    logic       winner;
    logic       load;
    logic [7:0] win_data;

    // ptr names the preferred requester; the other one wins only when the
    // preferred one has nothing pending.
    always_comb begin
        winner = ptr ? req_valid[1] : ~req_valid[0];
    end

    // Gating with rst_n keeps ready low while reset is held even though the
    // serializer already sits in IDLE.
    assign load     = (|req_valid) && !busy && rst_n;
    assign win_data = winner ? req_data1 : req_data0;

    always_comb begin
        req_ready = 2'b00;
        if (load) begin
            req_ready = winner ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr      <= 1'b0;
            grant_id <= 1'b0;
        end else if (load) begin
            grant_id <= winner;
            ptr      <= ~winner;
        end
    end

    uart_tx_serializer #(
        .BAUDRATE_CNT (BAUDRATE_CNT)
    ) u_serializer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .data  (win_data),
        .busy  (busy),
        .done  (frame_done),
        .tx    (uart_tx)
    );

endmodule : uart_tx_arbiter
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_arbiter
// Description : Self-checking bench for uart_tx_arbiter with BAUDRATE_CNT=4.
//               Frame records are applied from a table; reset corner cases are
//               written out by hand.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

    localparam int BAUD  = 4;
    localparam int FRAME = 10 * BAUD;

    logic       clk;
    logic       rst_n;
    logic [1:0] req_valid;
    logic [7:0] req_data0;
    logic [7:0] req_data1;
    logic [1:0] req_ready;
    logic       uart_tx;
    logic       busy;
    logic       grant_id;
    logic       frame_done;

    int tests;
    int fails;
    int cyc;

    uart_tx_arbiter #(
        .BAUDRATE_CNT (BAUD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_data0  (req_data0),
        .req_data1  (req_data1),
        .req_ready  (req_ready),
        .uart_tx    (uart_tx),
        .busy       (busy),
        .grant_id   (grant_id),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit         do_reset;
        logic [1:0] valid;
        logic [7:0] d0;
        logic [7:0] d1;
        logic [1:0] exp_ready;
        logic       exp_grant;
        logic [7:0] exp_byte;
        bit         chk_gap;
        bit         mid_en;
        logic [1:0] mid_a;   // valid applied at frame offset 12
        logic [1:0] mid_b;   // valid applied at frame offset 24
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected line level at offset o (1..FRAME) after the accept cycle.
    function automatic logic exp_line(input logic [7:0] b, input int o);
        if (o <= BAUD)          return 1'b0;
        else if (o <= 9 * BAUD) return b[(o - BAUD - 1) / BAUD];
        else                    return 1'b1;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        req_valid = 2'b00;
        rst_n     = 1'b0;
        repeat (2) @(negedge clk);
        rst_n     = 1'b1;
    endtask

    task automatic idle_hold(input int n, input string name);
        int bad;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk); #1;
            if (uart_tx !== 1'b1 || busy !== 1'b0 || req_ready !== 2'b00 || frame_done !== 1'b0)
                bad++;
        end
        chk(name, bad, 0);
    endtask

    // Called at a negedge with inputs applied; waits for the accept cycle k,
    // then checks cycles k+1..k+FRAME and the idle cycle k+FRAME+1.
    task automatic run_frame(input vec_t v, output int start);
        bit found;
        int k;
        int bad_tx, bad_busy, bad_fd, bad_rdy;
        found = 1'b0;
        start = -1;
        for (int t = 0; t < 200; t++) begin
            #1;
            if (req_ready !== 2'b00) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!found) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: got no req_ready, expected %0b", v.exp_ready);
            return;
        end
        chk("req_ready", req_ready, v.exp_ready);
        k      = cyc;
        start  = k + 1;
        bad_tx = 0; bad_busy = 0; bad_fd = 0; bad_rdy = 0;
        for (int o = 1; o <= FRAME; o++) begin
            @(negedge clk); #1;
            if (uart_tx !== exp_line(v.exp_byte, o)) begin
                if (bad_tx == 0)
                    $display("FAIL line_bit: got %0b expected %0b at offset %0d", uart_tx, exp_line(v.exp_byte, o), o);
                bad_tx++;
            end
            if (busy !== 1'b1)                    bad_busy++;
            if (frame_done !== (o == FRAME))      bad_fd++;
            if (req_ready !== 2'b00)              bad_rdy++;
            if (o == 1) chk("grant_id", grant_id, v.exp_grant);
            if (v.mid_en && o == 12) req_valid = v.mid_a;
            if (v.mid_en && o == 24) req_valid = v.mid_b;
        end
        chk("line_errors",  bad_tx,   0);
        chk("busy_errors",  bad_busy, 0);
        chk("frame_done_errors", bad_fd, 0);
        chk("ready_in_frame", bad_rdy, 0);
        @(negedge clk); #1;
        chk("post_busy", busy, 1'b0);
        chk("post_line", uart_tx, 1'b1);
        chk("grant_hold", grant_id, v.exp_grant);
    endtask

    initial begin
        int prev;
        int start;
        bit found;
        tests     = 0;
        fails     = 0;
        rst_n     = 1'b0;
        req_valid = 2'b11;
        req_data0 = 8'h00;
        req_data1 = 8'h00;

        repeat (2) @(negedge clk);
        #1;
        chk("rst_uart_tx",    uart_tx,    1'b1);
        chk("rst_busy",       busy,       1'b0);
        chk("rst_grant_id",   grant_id,   1'b0);
        chk("rst_frame_done", frame_done, 1'b0);
        chk("rst_req_ready",  req_ready,  2'b00);

        //         rst  valid  d0     d1     ready  g     byte   gap  mid  a      b
        vecs[0] = '{1'b1, 2'b01, 8'hA5, 8'h00, 2'b01, 1'b0, 8'hA5, 1'b0, 1'b0, 2'b00, 2'b00};
        vecs[1] = '{1'b1, 2'b11, 8'h11, 8'h22, 2'b01, 1'b0, 8'h11, 1'b0, 1'b0, 2'b00, 2'b00};
        vecs[2] = '{1'b0, 2'b11, 8'h11, 8'h22, 2'b10, 1'b1, 8'h22, 1'b1, 1'b0, 2'b00, 2'b00};
        vecs[3] = '{1'b0, 2'b11, 8'h11, 8'h22, 2'b01, 1'b0, 8'h11, 1'b1, 1'b0, 2'b00, 2'b00};
        vecs[4] = '{1'b0, 2'b11, 8'h11, 8'h22, 2'b10, 1'b1, 8'h22, 1'b1, 1'b0, 2'b00, 2'b00};
        vecs[5] = '{1'b0, 2'b10, 8'h00, 8'h5A, 2'b10, 1'b1, 8'h5A, 1'b1, 1'b0, 2'b00, 2'b00};
        vecs[6] = '{1'b0, 2'b10, 8'h00, 8'hC3, 2'b10, 1'b1, 8'hC3, 1'b1, 1'b0, 2'b00, 2'b00};
        vecs[7] = '{1'b1, 2'b01, 8'h3C, 8'h96, 2'b01, 1'b0, 8'h3C, 1'b0, 1'b1, 2'b11, 2'b10};
        vecs[8] = '{1'b0, 2'b10, 8'h3C, 8'h96, 2'b10, 1'b1, 8'h96, 1'b1, 1'b0, 2'b00, 2'b00};
        vecs[9] = '{1'b0, 2'b10, 8'h77, 8'hE1, 2'b10, 1'b1, 8'hE1, 1'b1, 1'b1, 2'b11, 2'b00};

        prev = -1;
        for (int i = 0; i < 10; i++) begin
            if (vecs[i].do_reset) begin
                do_reset();
                prev = -1;
            end
            req_valid = vecs[i].valid;
            req_data0 = vecs[i].d0;
            req_data1 = vecs[i].d1;
            run_frame(vecs[i], start);
            if (vecs[i].chk_gap && prev >= 0 && start >= 0)
                chk("frame_spacing", start - prev, FRAME + 1);
            prev = start;
        end

        // Port 0 withdrew during the last frame: nothing more may be sent.
        idle_hold(60, "withdraw_idle");

        // Reset in the middle of a frame of zeros: line must rise at once.
        req_valid = 2'b01;
        req_data0 = 8'h00;
        found     = 1'b0;
        for (int t = 0; t < 200; t++) begin
            #1;
            if (req_ready !== 2'b00) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("midrst_accept", found, 1'b1);
        @(negedge clk);
        req_valid = 2'b00;
        repeat (14) @(negedge clk);
        #1;
        chk("midrst_line_low", uart_tx, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_uart_tx", uart_tx, 1'b1);
        chk("midrst_busy",    busy,    1'b0);
        chk("midrst_grant",   grant_id, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_hold(60, "post_reset_idle");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule : tb_uart_tx_arbiter
`default_nettype wire
